// File: rtl/evdev_uart_tx.sv
// evdev_uart_tx: buffers 32-bit key events in a FIFO and sends each one as four
// 8N1 UART bytes, most significant byte first.
// Ports:
//   clk_100mhz - system clock
//   nrst       - asynchronous active-low reset
//   data       - event word, sampled when done=1
//   done       - one-cycle write strobe
//   uart_tx    - serial line, idle high
//   busy       - serializer not idle
//   level      - FIFO occupancy 0..DEPTH
//   overflow   - sticky flag, set when an event is dropped
module evdev_uart_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_100mhz,
    input  logic                     nrst,
    input  logic [31:0]              data,
    input  logic                     done,
    output logic                     uart_tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     sh_q, sh_d;
    logic [7:0]      byte_q, byte_d;
    logic            tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic [31:0]     mem_q [DEPTH];
    logic            push, pop, bit_end;

    // Full is judged on the registered level, so a drop never depends on a concurrent pop.
    assign push    = done && (level_q != FULL);
    assign bit_end = cnt_q == CW'(DIV - 1);

    always_ff @(posedge clk_100mhz or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= data;
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        pop     = 1'b0;
        cnt_d   = (state_q == START || state_q == DATA || state_q == STOP) ?
                  (bit_end ? '0 : cnt_q + CW'(1)) : '0;
        case (state_q)
            IDLE:  if (level_q != '0) begin
                       pop     = 1'b1;
                       state_d = LOAD;
                   end
            LOAD:  begin
                       byte_d  = sh_q[{idx_q, 3'b000} +: 8];
                       state_d = START;
                   end
            START: if (bit_end) begin
                       state_d = DATA;
                       bit_d   = '0;
                   end
            DATA:  if (bit_end) begin
                       bit_d = bit_q + 3'd1;
                       if (bit_q == 3'd7) state_d = STOP;
                   end
            STOP:  if (bit_end) begin
                       if (idx_q != 2'd0) begin
                           idx_d   = idx_q - 2'd1;
                           state_d = LOAD;
                       end else if (level_q != '0) begin
                           // chain straight into the next event with no idle bit
                           pop     = 1'b1;
                           state_d = LOAD;
                       end else begin
                           state_d = IDLE;
                       end
                   end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            sh_d  = mem_q[rptr_q[AW-1:0]];
            idx_d = 2'd3;
        end
        wptr_d  = wptr_q + {{AW{1'b0}}, push};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop};
        level_d = wptr_d - rptr_d;
        ovf_d   = ovf_q | (done & ~push);
    end

    // Line level follows the state being entered so uart_tx stays a pure flop output.
    always_comb begin
        tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? byte_d[bit_d] : 1'b1;
        busy_d = state_d != IDLE;
    end

    assign uart_tx  = tx_q;
    assign busy     = busy_q;
    assign level    = level_q;
    assign overflow = ovf_q;
endmodule
